// File: rtl/gain_ramp.sv
// gain_ramp: programmable per-sample gain with click-free linear ramping.
// Gain changes and mute move gain_cur toward the effective target by at most
// RAMP_STEP per valid input sample. Samples are scaled by gain_cur (Q2.(GW-2))
// in a two-stage pipeline, then rounded half up and saturated to DW bits.
// Optional feature macro: GAIN_RAMP_CLIP_CNT_EN enables the saturating
// clip_count counter; otherwise clip_count is tied to 0.
module gain_ramp #(
  parameter int DW        = 24,
  parameter int GW        = 16,
  parameter int RAMP_STEP = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_sample,
  input  logic [GW-1:0] target_gain,
  input  logic          mute,
  output logic          out_valid,
  output logic [DW-1:0] out_sample,
  output logic [GW-1:0] gain_cur,
  output logic          ramp_busy,
  output logic          clip,
  output logic [15:0]   clip_count
);

  localparam int PW = DW + GW + 1;

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [GW-1:0]        STEP       = GW'(RAMP_STEP);
  localparam logic signed [PW-1:0] ROUND_BIAS = PW'(1) << (GW - 3);
  localparam logic signed [PW-1:0] SAT_MAX    = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN    = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [GW-1:0]        eff_target;
  logic [1:0]           ramp_state;
  logic [GW-1:0]        diff;
  logic [GW-1:0]        step;
  logic [GW-1:0]        gain_next;
  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod_q;
  logic                 valid_q;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic                 sat_hi;
  logic                 sat_lo;

  assign eff_target = mute ? '0 : target_gain;
  assign ramp_busy  = (gain_cur != eff_target);

  // Decide ramp direction and the clamped step so the gain never overshoots.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ramp_state = HOLD;
    diff       = '0;
    gain_next  = gain_cur;
    if (gain_cur < eff_target) begin
      ramp_state = UP;
      diff       = eff_target - gain_cur;
    end else if (gain_cur > eff_target) begin
      ramp_state = DOWN;
      diff       = gain_cur - eff_target;
    end
    step = (diff < STEP) ? diff : STEP;
    case (ramp_state)
      UP:      gain_next = gain_cur + step;
      DOWN:    gain_next = gain_cur - step;
      default: gain_next = gain_cur;
    endcase
  end

  // Advance the gain one step per accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      gain_cur <= '0;
    end else if (in_valid) begin
      gain_cur <= gain_next;
    end
  end

  assign sample_ext = PW'($signed(in_sample));
  assign gain_ext   = PW'($signed({1'b0, gain_cur}));

  // Stage 1: multiply the sample by the gain in effect before this update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        prod_q <= sample_ext * gain_ext;
      end
    end
  end

  assign rounded = prod_q + ROUND_BIAS;
  assign shifted = rounded >>> (GW - 2);
  assign sat_hi  = (shifted > SAT_MAX);
  assign sat_lo  = (shifted < SAT_MIN);

  // Stage 2: round, saturate and hold the result between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      clip       <= 1'b0;
    end else begin
      out_valid <= valid_q;
      if (valid_q) begin
        if (sat_hi) begin
          out_sample <= SAT_MAX[DW-1:0];
          clip       <= 1'b1;
        end else if (sat_lo) begin
          out_sample <= SAT_MIN[DW-1:0];
          clip       <= 1'b1;
        end else begin
          out_sample <= shifted[DW-1:0];
          clip       <= 1'b0;
        end
      end
    end
  end

`ifdef GAIN_RAMP_CLIP_CNT_EN
  // Count saturated output samples, sticking at the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_count <= '0;
    end else if (valid_q && (sat_hi || sat_lo) && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_gain_ramp.sv
// Directed self-checking bench for gain_ramp with hand-computed expectations.
module tb_gain_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_sample = '0;
  logic [15:0] target_gain = '0;
  logic        mute = 1'b0;
  logic        out_valid;
  logic [23:0] out_sample;
  logic [15:0] gain_cur;
  logic        ramp_busy;
  logic        clip;
  logic [15:0] clip_count;

  int checks = 0;
  int failures = 0;
  int seen_valid;

`ifdef GAIN_RAMP_CLIP_CNT_EN
  localparam int EXP_CLIPS = 2;
`else
  localparam int EXP_CLIPS = 0;
`endif

  gain_ramp dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .target_gain(target_gain),
    .mute       (mute),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .gain_cur   (gain_cur),
    .ramp_busy  (ramp_busy),
    .clip       (clip),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue n zero-valued strobes spaced two cycles apart to walk the ramp.
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      in_sample = '0;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
    end
  endtask

  // Send one sample and verify latency, value and clip flag.
  task automatic send(input string tag, input int s, input int exp_s, input int exp_clip);
    in_sample = 24'(s);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check({tag, "_valid_d1"}, out_valid, 0);
    tick();
    check({tag, "_valid_d2"}, out_valid, 1);
    check({tag, "_sample"}, $signed(out_sample), exp_s);
    check({tag, "_clip"}, clip, exp_clip);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state.
    repeat (2) tick();
    check("rst_gain", gain_cur, 0);
    check("rst_sample", $signed(out_sample), 0);
    check("rst_valid", out_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_clip_count", clip_count, 0);
    rst = 1'b1;
    tick();
    check("rst_busy", ramp_busy, 0);

    // Ramp timing from silence to unity.
    target_gain = 16'd16384;
    tick();
    check("ramp_busy_start", ramp_busy, 1);
    strobes(1);
    check("ramp_first", gain_cur, 16);
    repeat (5) tick();
    check("ramp_idle_hold", gain_cur, 16);
    strobes(511);
    check("ramp_half", gain_cur, 8192);
    strobes(511);
    check("ramp_1023", gain_cur, 16368);
    check("ramp_busy_1023", ramp_busy, 1);
    strobes(1);
    check("ramp_1024", gain_cur, 16384);
    check("ramp_done_busy", ramp_busy, 0);

    // Unity path.
    send("unity", 1000, 1000, 0);
    tick();
    check("hold_valid", out_valid, 0);
    check("hold_sample", $signed(out_sample), 1000);

    // Half gain with round half up.
    target_gain = 16'd8192;
    strobes(512);
    check("half_gain", gain_cur, 8192);
    send("half_pos", 1001, 501, 0);
    send("half_neg", -3, -1, 0);

    // Saturation at gain 2.0.
    target_gain = 16'd32768;
    strobes(1536);
    check("gain_two", gain_cur, 32768);
    send("sat_hi", 8388607, 8388607, 1);
    send("sat_lo", -8388608, -8388608, 1);
    check("clip_count", clip_count, EXP_CLIPS);
    send("post_sat", 100, 200, 0);
    check("clip_count_hold", clip_count, EXP_CLIPS);

    // Mute mid-ramp, reverse, then full mute and a short non-multiple ramp.
    do_reset();
    target_gain = 16'd16384;
    strobes(250);
    check("mute_start", gain_cur, 4000);
    mute = 1'b1;
    strobes(1);
    check("mute_first", gain_cur, 3984);
    strobes(239);
    check("mute_160", gain_cur, 160);
    check("mute_busy", ramp_busy, 1);
    mute = 1'b0;
    strobes(1);
    check("unmute_up", gain_cur, 176);
    mute = 1'b1;
    strobes(11);
    check("mute_zero", gain_cur, 0);
    check("mute_zero_busy", ramp_busy, 0);
    strobes(1);
    check("mute_no_wrap", gain_cur, 0);
    mute = 1'b0;
    target_gain = 16'd100;
    strobes(6);
    check("small_96", gain_cur, 96);
    strobes(1);
    check("small_100", gain_cur, 100);
    strobes(1);
    check("small_no_over", gain_cur, 100);

    // Reset between in_valid and out_valid.
    send("pre_rst", 1000000, 6104, 0);
    in_sample = 24'd1000;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    rst       = 1'b0;
    #1;
    check("mid_rst_gain", gain_cur, 0);
    check("mid_rst_sample", $signed(out_sample), 0);
    check("mid_rst_clip_count", clip_count, 0);
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b1;
      tick();
      if (out_valid) seen_valid++;
    end
    check("mid_rst_no_valid", seen_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gain_ramp.md
Name: gain_ramp

Overview:
Per-sample gain stage between the DDS output and the i2s_tx sample inputs. It replaces the fixed divide-by-8 scaling with a programmable gain. Gain changes and mute are applied as a linear ramp, one step per valid sample, to avoid zipper noise and clicks. Each output sample is rounded and saturated to DW bits.

Parameters:
DW, 24, sample width (signed, two's complement)
GW, 16, gain width (unsigned, Q2.(GW-2); unity = 2^(GW-2) = 16384)
RAMP_STEP, 16, gain LSBs moved per valid input sample while ramping

Ports:
clk  input  1  system clock (DAC mclk domain)
rst  input  1  asynchronous reset, active-low
in_valid  input  1  one-cycle strobe, in_sample valid (driven by DDS valid)
in_sample  input  DW  signed input sample
target_gain  input  GW  requested gain, sampled every cycle
mute  input  1  level; when high, effective target is 0
out_valid  output  1  one-cycle strobe, out_sample updated
out_sample  output  DW  signed scaled sample; held between strobes
gain_cur  output  GW  gain currently applied
ramp_busy  output  1  high while gain_cur != effective target
clip  output  1  high with out_valid when the current output saturated
clip_count  output  16  saturated-sample counter (optional feature)

Behaviour:
- Reset (rst low, async) sets all outputs and registers to 0. Sequence is gain_cur=0, out_sample=0, out_valid=0, clip=0, clip_count=0. The block fades in from silence after reset.
- eff_target = mute ? 0 : target_gain, evaluated combinationally each cycle.
- ramp_busy = (gain_cur != eff_target), combinational.
- Ramp state machine, evaluated on in_valid cycles only:
  - HOLD: gain_cur == eff_target; no change.
  - UP: gain_cur < eff_target; gain_cur += min(RAMP_STEP, eff_target - gain_cur).
  - DOWN: gain_cur > eff_target; gain_cur -= min(RAMP_STEP, gain_cur - eff_target).
  - The state is re-decided every in_valid cycle from the current eff_target. A target change or mute toggle mid-ramp reverses or redirects the ramp on the next valid sample.
  - The gain never overshoots the target and never wraps.
- The sample accepted on a given in_valid cycle uses the gain_cur value before that cycle's update.
- Pipeline stage 1 (registered):
  - prod = in_sample * signed({1'b0, gain_cur}), width DW+GW+1.
  - A valid bit is carried alongside.
- Pipeline stage 2 (registered):
  - r = (prod + 2^(GW-3)) >>> (GW-2), arithmetic shift, round half up.
  - If r > 2^(DW-1)-1, output 2^(DW-1)-1 and set clip=1.
  - If r < -2^(DW-1), output -2^(DW-1) and set clip=1.
  - Otherwise output r[DW-1:0] and set clip=0.
- Latency: out_valid asserts exactly 2 cycles after in_valid. Back-to-back in_valid every cycle is supported at full throughput.
- No back-pressure. i2s_tx latches out_sample at its own rd_en, and out_sample holds between strobes.
- in_valid low: the pipeline advances, out_valid goes low, and out_sample and clip hold their values.
- Reset mid-operation flushes both pipeline stages; no stale out_valid follows reset release.

Optional Feature:
- Macro: GAIN_RAMP_CLIP_CNT_EN.
- Defined: clip_count increments on every out_valid with clip=1 and saturates at 65535 (no wrap). It clears only on reset.
- Undefined: clip_count is constant 0 and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Unity path: force gain_cur to 16384 (target 16384, ramp complete), in_sample=1000 with in_valid -> 2 cycles later out_valid=1, out_sample=1000, clip=0.
- Half gain with rounding: gain 8192, in_sample=1001 -> out_sample=501. Also in_sample=-3 -> out_sample=-1 (round half up: -1.5 -> -1).
- Saturation: gain 32768 (2.0), in_sample=8388607 -> out_sample=8388607, clip=1. in_sample=-8388608 -> out_sample=-8388608, clip=1. With GAIN_RAMP_CLIP_CNT_EN, clip_count=2.
- Ramp timing: from reset, target_gain=16384 with in_valid every 256 cycles -> gain_cur increments by 16 per strobe. It reaches 16384 after exactly 1024 strobes, after which ramp_busy=0. No strobes means gain_cur is unchanged.
- Mute mid-ramp: at gain_cur=4000 ramping up, assert mute -> next strobe gain_cur=3984, then decreasing to 0 after 250 strobes total. Deassert mute at 160 -> ramp back up.
- Reset mid-stream: assert rst between in_valid and out_valid -> out_valid never pulses for that sample. gain_cur=0 and out_sample=0 immediately (async), clip_count=0.
